// File: rtl/johnson_pkg.sv
// Shared types and pure helpers for decoding Johnson-coded counter words.
// Functions take the word width as an argument and operate on MAX_N-bit zero-extended words.
package johnson_pkg;

  localparam int MAX_N = 16;

  typedef enum logic [1:0] {ACQ, TRACK, LOCKED} johnson_state_t;

  function automatic logic [MAX_N-1:0] johnson_mask(input int k);
    logic [MAX_N-1:0] m;
    m = '0;
    for (int j = 0; j < MAX_N; j++) begin
      if (j < k) m = {m[MAX_N-2:0], 1'b1};
    end
    return m;
  endfunction

  // Legal words are a single run of ones anchored at either end of the n-bit word.
  function automatic logic johnson_is_legal(input logic [MAX_N-1:0] code, input int n);
    logic [MAX_N-1:0] lsb_run;
    logic [MAX_N-1:0] msb_run;
    logic legal;
    legal = 1'b0;
    for (int k = 0; k <= MAX_N; k++) begin
      if (k <= n) begin
        lsb_run = johnson_mask(k);
        msb_run = johnson_mask(n) & ~johnson_mask(n - k);
        if (code == lsb_run || code == msb_run) legal = 1'b1;
      end
    end
    return legal;
  endfunction

  function automatic int johnson_to_index(input logic [MAX_N-1:0] code, input int n);
    logic [MAX_N-1:0] c;
    logic [MAX_N-1:0] msb_word;
    int pop;
    int idx;
    c = code;
    pop = 0;
    for (int j = 0; j < MAX_N; j++) begin
      pop += int'(c[0]);
      c = c >> 1;
    end
    msb_word = code >> (n - 1);
    if (!msb_word[0]) idx = n - pop;
    else if (pop == n) idx = 0;
    else idx = n + pop;
    return idx;
  endfunction

  function automatic int johnson_next(input int idx, input int states);
    return (idx + 1 >= states) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/johnson_decode_comb.sv
// Combinational Johnson word classifier: legality flag and sequence index.
module johnson_decode_comb
  import johnson_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(2 * N)
) (
  input  logic [N-1:0]  code,
  output logic          legal,
  output logic [IW-1:0] idx
);

  logic [MAX_N-1:0] wide;

  always_comb begin
    wide  = MAX_N'(code);
    legal = johnson_is_legal(wide, N);
    idx   = IW'(johnson_to_index(wide, N));
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson word decoder with sequence checking, lock tracking and a saturating error counter.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int N        = 4,
  parameter int IW       = $clog2(2 * N),
  parameter int LOCK_LEN = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     code_in,
  input  logic             code_valid,
  input  logic             err_clr,
  output logic [IW-1:0]    index_out,
  output logic             index_valid,
  output logic             illegal,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int GW = $clog2(LOCK_LEN + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  johnson_state_t state, next_state;
  logic [IW-1:0]  prev, next_prev;
  logic [GW-1:0]  good, next_good;
  logic           legal;
  logic [IW-1:0]  idx;
  logic           in_seq;
  logic           ill_ev;
  logic           seq_ev;
  logic           err_ev;

  johnson_decode_comb #(.N(N), .IW(IW)) u_decode (
    .code  (code_in),
    .legal (legal),
    .idx   (idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ACQ;
      prev        <= '0;
      good        <= '0;
      index_out   <= '0;
      index_valid <= 1'b0;
      illegal     <= 1'b0;
      seq_err     <= 1'b0;
      locked      <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= next_state;
      prev        <= next_prev;
      good        <= next_good;
      index_valid <= code_valid && legal;
      illegal     <= ill_ev;
      seq_err     <= seq_ev;
      locked      <= (next_state == LOCKED);
      if (code_valid && legal) index_out <= idx;
      // A clear coinciding with an error keeps that error counted.
      if (err_clr) err_count <= err_ev ? ERR_W'(1) : '0;
      else if (err_ev && err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    next_prev  = prev;
    next_good  = good;
    ill_ev     = 1'b0;
    seq_ev     = 1'b0;
    in_seq     = (idx == IW'(johnson_next(int'(prev), 2 * N)));
    if (code_valid) begin
      if (!legal) begin
        ill_ev     = 1'b1;
        next_state = ACQ;
        next_good  = '0;
      end else begin
        next_prev = idx;
        unique case (state)
          ACQ: begin
            next_good  = GW'(1);
            next_state = (LOCK_LEN == 1) ? LOCKED : TRACK;
          end
          TRACK: begin
            if (in_seq) begin
              next_good = good + GW'(1);
              if (next_good >= GW'(LOCK_LEN)) next_state = LOCKED;
            end else begin
              next_good = GW'(1);
            end
          end
          LOCKED: begin
            if (!in_seq) begin
              seq_ev     = 1'b1;
              next_good  = GW'(1);
              next_state = TRACK;
            end
          end
          default: next_state = ACQ;
        endcase
      end
    end
  end

  assign err_ev = ill_ev || seq_ev;

endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench: directed scenarios plus random traffic against a run-length reference model.
module tb_johnson_decoder;

  localparam int N        = 4;
  localparam int IW       = 3;
  localparam int LOCK_LEN = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  code_in;
  logic          code_valid;
  logic          err_clr;
  logic [IW-1:0] index_out, index_out_w2;
  logic          index_valid, index_valid_w2;
  logic          illegal, illegal_w2;
  logic          seq_err, seq_err_w2;
  logic          locked, locked_w2;
  logic [7:0]    err_count;
  logic [1:0]    err_count_w2;

  int errors;
  int checks;

  logic [3:0] seq_tbl [8];

  int m_index, m_run, m_prev, m_err8, m_err2;
  bit m_valid, m_ill, m_seq, m_locked;

  johnson_decoder #(.N(N), .LOCK_LEN(LOCK_LEN), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid), .err_clr(err_clr),
    .index_out(index_out), .index_valid(index_valid), .illegal(illegal),
    .seq_err(seq_err), .locked(locked), .err_count(err_count)
  );

  johnson_decoder #(.N(N), .LOCK_LEN(LOCK_LEN), .ERR_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid), .err_clr(err_clr),
    .index_out(index_out_w2), .index_valid(index_valid_w2), .illegal(illegal_w2),
    .seq_err(seq_err_w2), .locked(locked_w2), .err_count(err_count_w2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int refIndex(input logic [3:0] c);
    for (int i = 0; i < 8; i++) if (seq_tbl[i] == c) return i;
    return -1;
  endfunction

  task automatic modelReset();
    m_index = 0; m_run = 0; m_prev = 0; m_err8 = 0; m_err2 = 0;
    m_valid = 0; m_ill = 0; m_seq = 0; m_locked = 0;
  endtask

  // The model tracks the length of the current in-order run instead of an FSM state.
  task automatic modelStep(input bit v, input logic [3:0] c, input bit clr);
    int id;
    bit ev;
    m_valid = 0; m_ill = 0; m_seq = 0;
    if (v) begin
      id = refIndex(c);
      if (id < 0) begin
        m_ill = 1;
        m_run = 0;
      end else begin
        m_valid = 1;
        m_index = id;
        if (m_run == 0) m_run = 1;
        else if (id == (m_prev + 1) % 8) m_run = (m_run < LOCK_LEN) ? m_run + 1 : m_run;
        else begin
          if (m_run >= LOCK_LEN) m_seq = 1;
          m_run = 1;
        end
        m_prev = id;
      end
    end
    ev = m_ill || m_seq;
    if (clr) begin
      m_err8 = ev ? 1 : 0;
      m_err2 = ev ? 1 : 0;
    end else if (ev) begin
      if (m_err8 < 255) m_err8++;
      if (m_err2 < 3) m_err2++;
    end
    m_locked = (m_run >= LOCK_LEN);
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".index_out"}, int'(index_out), m_index);
    checkOutput({tag, ".index_valid"}, int'(index_valid), int'(m_valid));
    checkOutput({tag, ".illegal"}, int'(illegal), int'(m_ill));
    checkOutput({tag, ".seq_err"}, int'(seq_err), int'(m_seq));
    checkOutput({tag, ".locked"}, int'(locked), int'(m_locked));
    checkOutput({tag, ".err_count"}, int'(err_count), m_err8);
    checkOutput({tag, ".locked_w2"}, int'(locked_w2), int'(m_locked));
    checkOutput({tag, ".err_count_w2"}, int'(err_count_w2), m_err2);
  endtask

  task automatic applyStimulus(input string tag, input bit v, input logic [3:0] c, input bit clr);
    code_valid = v;
    code_in    = c;
    err_clr    = clr;
    @(posedge clk);
    #1;
    modelStep(v, c, clr);
    checkAll(tag);
  endtask

  initial begin
    logic [3:0] rc;
    bit         rv, rclr;
    errors = 0;
    checks = 0;
    seq_tbl = '{4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000, 4'b1100, 4'b1110};
    rst = 1'b0; code_in = '0; code_valid = 1'b0; err_clr = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    rst = 1'b1;

    for (int i = 0; i < 9; i++) applyStimulus("count", 1'b1, seq_tbl[i % 8], 1'b0);
    applyStimulus("illegal", 1'b1, 4'b0101, 1'b0);
    checkOutput("illegal.hold_index", int'(index_out), 0);

    applyStimulus("relock", 1'b1, 4'b1110, 1'b0);
    applyStimulus("relock", 1'b1, 4'b1111, 1'b0);
    applyStimulus("relock", 1'b1, 4'b0111, 1'b0);
    applyStimulus("relock", 1'b1, 4'b0011, 1'b0);
    applyStimulus("jump", 1'b1, 4'b1000, 1'b0);
    checkOutput("jump.seq_err", int'(seq_err), 1);
    applyStimulus("relock2", 1'b1, 4'b1100, 1'b0);
    applyStimulus("relock2", 1'b1, 4'b1110, 1'b0);
    applyStimulus("relock2", 1'b1, 4'b1111, 1'b0);
    applyStimulus("relock2", 1'b1, 4'b0111, 1'b0);

    repeat (3) applyStimulus("idle", 1'b0, 4'b1001, 1'b0);
    applyStimulus("resume", 1'b1, 4'b0011, 1'b0);

    applyStimulus("clr_alone", 1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus("sat", 1'b1, 4'b1001, 1'b0);
    checkOutput("sat.w2_max", int'(err_count_w2), 3);
    applyStimulus("clr_with_err", 1'b1, 4'b0101, 1'b1);
    applyStimulus("clr_only", 1'b0, 4'b0000, 1'b1);

    for (int i = 0; i < 400; i++) begin
      rv   = ($urandom_range(0, 9) < 8);
      rclr = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 9))
        0, 1:    rc = 4'($urandom_range(0, 15));
        2:       rc = seq_tbl[$urandom_range(0, 7)];
        default: rc = seq_tbl[(m_prev + 1) % 8];
      endcase
      applyStimulus("random", rv, rc, rclr);
    end

    // Build lock with err_count=2, then pull reset between clock edges.
    applyStimulus("pre_rst", 1'b0, 4'b0000, 1'b1);
    applyStimulus("pre_rst", 1'b1, 4'b1011, 1'b0);
    applyStimulus("pre_rst", 1'b1, 4'b1101, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus("pre_rst", 1'b1, seq_tbl[i], 1'b0);
    checkOutput("pre_rst.locked", int'(locked), 1);
    checkOutput("pre_rst.err_count", int'(err_count), 2);
    #2;
    rst = 1'b0;
    #1;
    modelReset();
    checkAll("async_rst");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("post_rst", 1'b1, 4'b0001, 1'b0);
    checkOutput("post_rst.index_valid", int'(index_valid), 1);
    checkOutput("post_rst.locked", int'(locked), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
